// File: rtl/syncore_pkg.sv
// Shared definitions for the syncore dual-port RAM: port-A read-mode encodings,
// the zero-fill sequencer state type and the write-lane count helper.
package syncore_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;
    localparam int NO_CHANGE   = 2;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    // Number of write-enable lanes; the top lane may be narrower than bw.
    function automatic int nbytes(input int dw, input int bw);
        return (dw + bw - 1) / bw;
    endfunction

endpackage

// File: rtl/syncore_ram_clr.sv
// Post-reset zero-fill sequencer: walks every word once after reset and owns the
// RAM write address while it runs, otherwise passes the user write through.
module syncore_ram_clr
    import syncore_pkg::*;
#(
    parameter int ADDRWIDTH      = 8,
    parameter int MEMDEPTH       = 2**ADDRWIDTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDRWIDTH-1:0] user_addr,
    input  logic                 user_we,
    output logic                 busy,
    output logic                 wr_en,
    output logic [ADDRWIDTH-1:0] wr_addr
);

    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(MEMDEPTH - 1);

    clr_state_t           state;
    logic [ADDRWIDTH-1:0] cnt;

    // busy is kept as its own register so the port sees a flop, not decode logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state <= CLR_RUN;
                busy  <= 1'b1;
            end else begin
                state <= CLR_IDLE;
                busy  <= 1'b0;
            end
        end else if (state == CLR_RUN) begin
            if (cnt == LAST_ADDR) begin
                state <= CLR_IDLE;
                busy  <= 1'b0;
            end else begin
                cnt  <= cnt + 1'b1;
                busy <= 1'b1;
            end
        end else begin
            busy <= 1'b0;
        end
    end

    assign wr_addr = busy ? cnt : user_addr;
    assign wr_en   = busy | user_we;

endmodule

// File: rtl/syncore_dpram.sv
// Single-clock RAM: port A read/write with byte lanes and selectable collision
// behaviour, port B read-only, optional output registers and zero-fill on reset.
module syncore_dpram
    import syncore_pkg::*;
#(
    parameter int  DATAWIDTH         = 32,
    parameter int  ADDRWIDTH         = 8,
    parameter int  MEMDEPTH          = 2**ADDRWIDTH,
    parameter int  BYTEWIDTH         = 8,
    parameter int  READ_MODE_A       = READ_FIRST,
    parameter int  REGISTER_OUTPUT_A = 1,
    parameter int  REGISTER_OUTPUT_B = 1,
    parameter int  CLEAR_ON_RESET    = 1,
    localparam int NBYTES            = nbytes(DATAWIDTH, BYTEWIDTH)
) (
    input  logic                 PortClk,
    input  logic                 PortReset,
    input  logic [ADDRWIDTH-1:0] PortAAddr,
    input  logic [DATAWIDTH-1:0] PortADataIn,
    input  logic                 PortAWriteEnable,
    input  logic [NBYTES-1:0]    PortAByteEnable,
    input  logic                 PortAReadEnable,
    input  logic                 PortAOutEnable,
    output logic [DATAWIDTH-1:0] PortADataOut,
    input  logic [ADDRWIDTH-1:0] PortBAddr,
    input  logic                 PortBReadEnable,
    input  logic                 PortBOutEnable,
    output logic [DATAWIDTH-1:0] PortBDataOut,
    output logic                 ClearBusy
);

    localparam int                   IDXW      = $clog2(MEMDEPTH);
    localparam logic [ADDRWIDTH:0]   DEPTH_LIM = (ADDRWIDTH + 1)'(MEMDEPTH);

    logic [DATAWIDTH-1:0] mem [MEMDEPTH];

    logic                 a_in_range;
    logic                 b_in_range;
    logic                 user_write;
    logic                 clr_busy;
    logic                 wr_en;
    logic [ADDRWIDTH-1:0] wr_addr;
    logic [DATAWIDTH-1:0] lane_mask;
    logic [DATAWIDTH-1:0] word_a;
    logic [DATAWIDTH-1:0] word_b;
    logic [DATAWIDTH-1:0] merged_a;
    logic [DATAWIDTH-1:0] wr_data;
    logic [DATAWIDTH-1:0] rd_a_p1;
    logic [DATAWIDTH-1:0] rd_b_p1;

    assign a_in_range = {1'b0, PortAAddr} < DEPTH_LIM;
    assign b_in_range = {1'b0, PortBAddr} < DEPTH_LIM;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < DATAWIDTH; i++) begin
            lane_mask[i] = PortAByteEnable[i / BYTEWIDTH];
        end
    end

    assign word_a     = a_in_range ? mem[PortAAddr[IDXW-1:0]] : '0;
    assign word_b     = b_in_range ? mem[PortBAddr[IDXW-1:0]] : '0;
    assign merged_a   = (word_a & ~lane_mask) | (PortADataIn & lane_mask);
    assign user_write = PortAWriteEnable & a_in_range & ~clr_busy;
    assign wr_data    = clr_busy ? '0 : merged_a;
    assign ClearBusy  = clr_busy;

    syncore_ram_clr #(
        .ADDRWIDTH      (ADDRWIDTH),
        .MEMDEPTH       (MEMDEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr (
        .clk       (PortClk),
        .rst       (PortReset),
        .user_addr (PortAAddr),
        .user_we   (user_write),
        .busy      (clr_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr)
    );

    // Array is never reset; only the sequencer zero-fills it.
    always_ff @(posedge PortClk) begin
        if (wr_en) begin
            mem[wr_addr[IDXW-1:0]] <= wr_data;
        end
    end

    // ---- p1: read stage ----
    always_ff @(posedge PortClk) begin
        if (PortReset) begin
            rd_a_p1 <= '0;
            rd_b_p1 <= '0;
        end else begin
            if (PortAReadEnable) begin
                if (clr_busy || !a_in_range) begin
                    rd_a_p1 <= '0;
                end else if (READ_MODE_A == WRITE_FIRST) begin
                    rd_a_p1 <= user_write ? merged_a : word_a;
                end else if (READ_MODE_A == NO_CHANGE) begin
                    if (!user_write) rd_a_p1 <= word_a;
                end else begin
                    rd_a_p1 <= word_a;
                end
            end
            if (PortBReadEnable) begin
                rd_b_p1 <= clr_busy ? '0 : word_b;
            end
        end
    end

    // ---- p2: optional output registers ----
    generate
        if (REGISTER_OUTPUT_A != 0) begin : g_out_a
            logic [DATAWIDTH-1:0] out_a_p2;
            always_ff @(posedge PortClk) begin
                if (PortReset)           out_a_p2 <= '0;
                else if (PortAOutEnable) out_a_p2 <= rd_a_p1;
            end
            assign PortADataOut = out_a_p2;
        end else begin : g_comb_a
            assign PortADataOut = rd_a_p1;
        end

        if (REGISTER_OUTPUT_B != 0) begin : g_out_b
            logic [DATAWIDTH-1:0] out_b_p2;
            always_ff @(posedge PortClk) begin
                if (PortReset)           out_b_p2 <= '0;
                else if (PortBOutEnable) out_b_p2 <= rd_b_p1;
            end
            assign PortBDataOut = out_b_p2;
        end else begin : g_comb_b
            assign PortBDataOut = rd_b_p1;
        end
    endgenerate

endmodule

// File: tb/tb_syncore_dpram.sv
// Bench for syncore_dpram: read-mode variants, a 200-word instance and a
// no-clear, unregistered instance all share one stimulus stream.
module tb_syncore_dpram;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_din;
    logic        a_we, a_re, a_oe, b_re, b_oe;
    logic [3:0]  a_be;

    logic [31:0] m0_a, m0_b, m1_a, m1_b, m2_a, m2_b, d2_a, d2_b, nc_a, nc_b;
    logic        m0_busy, m1_busy, m2_busy, d2_busy, nc_busy;

    always #5 clk = ~clk;

    syncore_dpram #(.READ_MODE_A(0)) u_m0 (
        .PortClk(clk), .PortReset(rst), .PortAAddr(a_addr), .PortADataIn(a_din),
        .PortAWriteEnable(a_we), .PortAByteEnable(a_be), .PortAReadEnable(a_re),
        .PortAOutEnable(a_oe), .PortADataOut(m0_a), .PortBAddr(b_addr),
        .PortBReadEnable(b_re), .PortBOutEnable(b_oe), .PortBDataOut(m0_b),
        .ClearBusy(m0_busy));

    syncore_dpram #(.READ_MODE_A(1)) u_m1 (
        .PortClk(clk), .PortReset(rst), .PortAAddr(a_addr), .PortADataIn(a_din),
        .PortAWriteEnable(a_we), .PortAByteEnable(a_be), .PortAReadEnable(a_re),
        .PortAOutEnable(a_oe), .PortADataOut(m1_a), .PortBAddr(b_addr),
        .PortBReadEnable(b_re), .PortBOutEnable(b_oe), .PortBDataOut(m1_b),
        .ClearBusy(m1_busy));

    syncore_dpram #(.READ_MODE_A(2)) u_m2 (
        .PortClk(clk), .PortReset(rst), .PortAAddr(a_addr), .PortADataIn(a_din),
        .PortAWriteEnable(a_we), .PortAByteEnable(a_be), .PortAReadEnable(a_re),
        .PortAOutEnable(a_oe), .PortADataOut(m2_a), .PortBAddr(b_addr),
        .PortBReadEnable(b_re), .PortBOutEnable(b_oe), .PortBDataOut(m2_b),
        .ClearBusy(m2_busy));

    syncore_dpram #(.MEMDEPTH(200)) u_d2 (
        .PortClk(clk), .PortReset(rst), .PortAAddr(a_addr), .PortADataIn(a_din),
        .PortAWriteEnable(a_we), .PortAByteEnable(a_be), .PortAReadEnable(a_re),
        .PortAOutEnable(a_oe), .PortADataOut(d2_a), .PortBAddr(b_addr),
        .PortBReadEnable(b_re), .PortBOutEnable(b_oe), .PortBDataOut(d2_b),
        .ClearBusy(d2_busy));

    syncore_dpram #(.CLEAR_ON_RESET(0), .REGISTER_OUTPUT_A(0), .REGISTER_OUTPUT_B(0)) u_nc (
        .PortClk(clk), .PortReset(rst), .PortAAddr(a_addr), .PortADataIn(a_din),
        .PortAWriteEnable(a_we), .PortAByteEnable(a_be), .PortAReadEnable(a_re),
        .PortAOutEnable(a_oe), .PortADataOut(nc_a), .PortBAddr(b_addr),
        .PortBReadEnable(b_re), .PortBOutEnable(b_oe), .PortBDataOut(nc_b),
        .ClearBusy(nc_busy));

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    sb_t  sbq[$];
    vec_t tbl[7];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0:       return m0_a;
            1:       return m0_b;
            2:       return m1_a;
            3:       return m2_a;
            4:       return d2_a;
            5:       return d2_b;
            6:       return nc_a;
            default: return nc_b;
        endcase
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    task automatic expect_at(input int lat, input int sel, input logic [31:0] exp, input string name);
        sb_t e;
        e.due  = cyc + lat;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Outputs are compared on the falling edge; inputs change 1ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                chk(sbq[i].name, pick(sbq[i].sel), sbq[i].exp);
                sbq.delete(i);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 10) begin
            tick();
            n++;
        end
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        a_addr = addr;
        a_din  = data;
        a_be   = be;
        a_we   = 1'b1;
        tick();
        a_we   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  n0, n2, n;
        bit  nc_seen;

        tbl[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'b0101, 32'h00AD00EF};
        tbl[1] = '{1'b1, 8'h10, 32'h12345678, 4'b1010, 32'h12AD56EF};
        tbl[2] = '{1'b1, 8'h20, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
        tbl[3] = '{1'b1, 8'h20, 32'h00000000, 4'b0000, 32'hCAFEF00D};
        tbl[4] = '{1'b1, 8'hFF, 32'hA5A5A5A5, 4'b1000, 32'hA5000000};
        tbl[5] = '{1'b1, 8'h00, 32'hFFFFFFFF, 4'b0001, 32'h000000FF};
        tbl[6] = '{1'b0, 8'h20, 32'h11111111, 4'b1111, 32'hCAFEF00D};

        rst = 1'b1; a_addr = '0; b_addr = '0; a_din = '0; a_be = '0;
        a_we = 1'b0; a_re = 1'b0; b_re = 1'b0; a_oe = 1'b1; b_oe = 1'b1;
        repeat (3) tick();
        chk("rst_out_a", m0_a, 32'h0);
        chk("rst_out_b", m0_b, 32'h0);
        chk("nc_busy_rst", {31'b0, nc_busy}, 32'h0);

        // Zero-fill length for both depths.
        rst = 1'b0;
        n0 = 0; n2 = 0; nc_seen = 1'b0;
        while (m0_busy && n0 < 1000) begin
            if (d2_busy) n2++;
            if (nc_busy) nc_seen = 1'b1;
            tick();
            n0++;
        end
        chk("clear_len_256", 32'(n0), 32'd256);
        chk("clear_len_200", 32'(n2), 32'd200);
        chk("nc_never_busy", {31'b0, nc_seen}, 32'h0);

        a_addr = 8'h7F; a_re = 1'b1; b_addr = 8'h7F; b_re = 1'b1;
        expect_at(2, 0, 32'h0, "cleared_a_7f");
        expect_at(2, 1, 32'h0, "cleared_b_7f");
        tick();
        a_re = 1'b0; b_re = 1'b0;
        drain();

        for (int i = 0; i < 7; i++) begin
            a_addr = tbl[i].addr; a_din = tbl[i].din; a_be = tbl[i].be; a_we = tbl[i].we;
            tick();
            a_we = 1'b0;
            b_addr = tbl[i].addr; b_re = 1'b1;
            expect_at(2, 1, tbl[i].exp, $sformatf("tbl%0d", i));
            tick();
            b_re = 1'b0;
        end
        drain();

        // Port B reading the word port A is writing in the same cycle.
        wr(8'h30, 32'h22222222, 4'b1111);
        a_addr = 8'h30; a_din = 32'h11111111; a_be = 4'b1111; a_we = 1'b1;
        b_addr = 8'h30; b_re = 1'b1;
        expect_at(2, 1, 32'h22222222, "collide_b_old");
        expect_at(1, 7, 32'h22222222, "collide_nc_old");
        tick();
        a_we = 1'b0;
        expect_at(2, 1, 32'h11111111, "collide_b_new");
        tick();
        b_re = 1'b0;
        drain();

        // Port A read-mode behaviour on read+write of the same word.
        wr(8'h40, 32'h000000AA, 4'b1111);
        a_addr = 8'h30; a_re = 1'b1;
        tick();
        a_addr = 8'h40; a_din = 32'h00000055; a_be = 4'b1111; a_we = 1'b1;
        expect_at(2, 0, 32'h000000AA, "mode0_rw");
        expect_at(2, 2, 32'h00000055, "mode1_rw");
        expect_at(2, 3, 32'h11111111, "mode2_rw");
        tick();
        a_we = 1'b0;
        expect_at(2, 0, 32'h00000055, "mode0_rd");
        expect_at(2, 2, 32'h00000055, "mode1_rd");
        expect_at(2, 3, 32'h00000055, "mode2_rd");
        tick();
        a_din = 32'h12345699; a_be = 4'b0001; a_we = 1'b1;
        expect_at(2, 0, 32'h00000055, "mode0_partial");
        expect_at(2, 2, 32'h00000099, "mode1_partial");
        expect_at(2, 3, 32'h00000055, "mode2_partial");
        tick();
        a_we = 1'b0; a_re = 1'b0;
        drain();

        // Output-register enable and read-stage hold.
        b_addr = 8'h20; b_re = 1'b1;
        tick();
        b_re = 1'b0; b_oe = 1'b0;
        tick();
        chk("oe_hold", m0_b, 32'h11111111);
        b_oe = 1'b1;
        tick();
        chk("oe_load", m0_b, 32'hCAFEF00D);
        tick();
        tick();
        chk("rd_stage_hold", m0_b, 32'hCAFEF00D);

        // Out-of-range access on the 200-word instance.
        wr(8'h08, 32'h08080808, 4'b1111);
        wr(8'hC8, 32'hC8C8C8C8, 4'b1111);
        a_addr = 8'hC8; a_re = 1'b1; b_addr = 8'h08; b_re = 1'b1;
        expect_at(2, 4, 32'h0, "oor_read_zero");
        expect_at(2, 5, 32'h08080808, "oor_no_alias");
        expect_at(2, 0, 32'hC8C8C8C8, "inrange_c8");
        expect_at(2, 1, 32'h08080808, "inrange_08");
        tick();
        a_re = 1'b0; b_re = 1'b0;
        drain();

        // Reset clears outputs; a second reset mid-clear restarts the sweep.
        rst = 1'b1;
        tick();
        chk("rst2_out_a", m0_a, 32'h0);
        chk("rst2_out_b", m0_b, 32'h0);
        chk("rst2_nc_a", nc_a, 32'h0);
        chk("busy_in_rst", {31'b0, m0_busy}, 32'h1);
        rst = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (m0_busy && n < 1000) begin
            if (n == 50) begin
                a_addr = 8'h10; a_din = 32'hFFFFFFFF; a_be = 4'b1111; a_we = 1'b1;
                b_addr = 8'hFF; b_re = 1'b1;
                expect_at(2, 1, 32'h0, "busy_read_zero");
            end else begin
                a_we = 1'b0; b_re = 1'b0;
            end
            tick();
            n++;
        end
        a_we = 1'b0; b_re = 1'b0;
        chk("restart_len", 32'(n), 32'd256);
        chk("nc_busy_after", {31'b0, nc_busy}, 32'h0);

        b_addr = 8'h10; b_re = 1'b1; a_addr = 8'hFF; a_re = 1'b1;
        expect_at(2, 1, 32'h0, "busy_write_ignored");
        expect_at(2, 0, 32'h0, "recleared_ff");
        tick();
        b_addr = 8'h30; a_re = 1'b0;
        expect_at(1, 7, 32'h11111111, "nc_keeps_mem");
        tick();
        b_re = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
